// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x-oversampling UART receiver that frames start/data/parity/stop and presents a parallel byte with error flags.
//
// Ports
//   clock       in   1  system clock, rising edge
//   ResetN      in   1  asynchronous active-low reset
//   SerialIn    in   1  serial line, idle high, asynchronous to clock
//   BaudRate    in   2  00=2400 01=4800 10=9600 11=19200 baud
//   ParityType  in   2  00/11=none 01=odd 10=even
//   DataLength  in   1  0=7 data bits, 1=8 data bits
//   StopBits    in   1  0=1 stop bit, 1=2 stop bits
//   DataOut     out  8  received data, LSB first on the line, bit7=0 in 7-bit mode
//   ErrorFlag   out  3  {StopError, StartError, ParityError}
//   ActiveFlag  out  1  high while a frame is being received
//   DoneFlag    out  1  one-cycle pulse, DataOut/ErrorFlag valid
//
// Build option
//   RX_MAJORITY_VOTE_EN  when defined, each bit is the majority of the samples at
//                        ticks 7, 8 and 9; otherwise a single sample at tick 8.
module uart_rx_unit #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       ResetN,
    input  logic       SerialIn,
    input  logic [1:0] BaudRate,
    input  logic [1:0] ParityType,
    input  logic       DataLength,
    input  logic       StopBits,
    output logic [7:0] DataOut,
    output logic [2:0] ErrorFlag,
    output logic       ActiveFlag,
    output logic       DoneFlag
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    // Rounded clocks per oversample tick.
    function automatic logic [15:0] baud_div(input int baud);
        return 16'((CLK_FREQ + OVERSAMPLE * baud / 2) / (OVERSAMPLE * baud));
    endfunction

    localparam logic [15:0] DIV_2400  = baud_div(2400);
    localparam logic [15:0] DIV_4800  = baud_div(4800);
    localparam logic [15:0] DIV_9600  = baud_div(9600);
    localparam logic [15:0] DIV_19200 = baud_div(19200);

`ifdef RX_MAJORITY_VOTE_EN
    // Decision is taken on the last of the three vote samples.
    localparam int SAMPLE_TICK = OVERSAMPLE / 2 + 1;
`else
    localparam int SAMPLE_TICK = OVERSAMPLE / 2;
`endif

    logic        sync1_q, sync2_q, rx;
    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [1:0]  baud_q, baud_d;
    logic [1:0]  par_q, par_d;
    logic        len_q, len_d;
    logic        stop_q, stop_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_err_q, par_err_d;
    logic        stop_err_q, stop_err_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  err_q, err_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0]  vote_q, vote_d;
`endif

    logic [15:0] div_sel;
    logic        tick, sample, bit_val, last_data, par_en, par_bad;

    assign rx         = sync2_q;
    assign DataOut    = data_q;
    assign ErrorFlag  = err_q;
    assign ActiveFlag = active_q;
    assign DoneFlag   = done_q;

    always_comb begin
        div_sel   = baud_q == 2'd0 ? DIV_2400 :
                    baud_q == 2'd1 ? DIV_4800 :
                    baud_q == 2'd2 ? DIV_9600 : DIV_19200;
        tick      = div_cnt_q == div_sel - 16'd1;
        // Samples fire on the tick that advances the bit-phase counter onto SAMPLE_TICK.
        sample    = tick && tick_cnt_q == 4'(SAMPLE_TICK - 1);
`ifdef RX_MAJORITY_VOTE_EN
        vote_d    = vote_q;
        if (tick && tick_cnt_q == 4'(SAMPLE_TICK - 3))
            vote_d[0] = rx;
        if (tick && tick_cnt_q == 4'(SAMPLE_TICK - 2))
            vote_d[1] = rx;
        bit_val   = (vote_q[0] & vote_q[1]) | (rx & (vote_q[0] | vote_q[1]));
`else
        bit_val   = rx;
`endif
        last_data = bit_cnt_q == (len_q ? 3'd7 : 3'd6);
        par_en    = par_q[0] ^ par_q[1];
        // Odd parity (01) expects data^parity to be 1, even (10) expects 0.
        par_bad   = bit_val ^ (^shift_q) ^ par_q[0];
        state_d    = state_q;
        armed_d    = armed_q;
        baud_d     = baud_q;
        par_d      = par_q;
        len_d      = len_q;
        stop_d     = stop_q;
        div_cnt_d  = tick ? 16'd0 : div_cnt_q + 16'd1;
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        err_d      = err_q;
        active_d   = active_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A start edge only counts once the line has been seen idle high.
                armed_d = armed_q | rx;
                if (armed_q && !rx) begin
                    state_d    = START;
                    armed_d    = 1'b0;
                    baud_d     = BaudRate;
                    par_d      = ParityType;
                    len_d      = DataLength;
                    stop_d     = StopBits;
                    div_cnt_d  = 16'd0;
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    shift_d    = 8'd0;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                    active_d   = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    if (!bit_val) begin
                        state_d = DATA;
                    end else begin
                        state_d  = DONE;
                        err_d    = 3'b010;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d[bit_cnt_q] = bit_val;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (last_data)
                        state_d = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    par_err_d = par_bad;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    stop_cnt_d = 1'b1;
                    stop_err_d = stop_err_q | !bit_val;
                    if (!(stop_q && !stop_cnt_q)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        data_d   = shift_q;
                        err_d    = {stop_err_q | !bit_val, 1'b0, par_err_q};
                    end
                end
            end
            DONE: begin
                // Arms immediately if the line is already back high, so a back-to-back
                // start edge is accepted in the first IDLE cycle; a break keeps it disarmed.
                armed_d = rx;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            baud_q     <= 2'd0;
            par_q      <= 2'd0;
            len_q      <= 1'b0;
            stop_q     <= 1'b0;
            div_cnt_q  <= 16'd0;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'd0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= 8'd0;
            err_q      <= 3'd0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
            vote_q     <= 2'd0;
`endif
        end else begin
            sync1_q    <= SerialIn;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            armed_q    <= armed_d;
            baud_q     <= baud_d;
            par_q      <= par_d;
            len_q      <= len_d;
            stop_q     <= stop_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            err_q      <= err_d;
            active_q   <= active_d;
            done_q     <= done_d;
`ifdef RX_MAJORITY_VOTE_EN
            vote_q     <= vote_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: self-checking bench for uart_rx_unit using a frame-level transmitter and result model.
// The clock frequency is scaled down so that one bit lasts 256/128/64/32 clocks at 2400/4800/9600/19200.
module tb_uart_rx_unit;
    localparam int CLK_FREQ = 614_400;

    logic       clock = 1'b0;
    logic       ResetN;
    logic       SerialIn;
    logic [1:0] BaudRate;
    logic [1:0] ParityType;
    logic       DataLength;
    logic       StopBits;
    logic [7:0] DataOut;
    logic [2:0] ErrorFlag;
    logic       ActiveFlag;
    logic       DoneFlag;

    always #5 clock = ~clock;

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
        .clock(clock),
        .ResetN(ResetN),
        .SerialIn(SerialIn),
        .BaudRate(BaudRate),
        .ParityType(ParityType),
        .DataLength(DataLength),
        .StopBits(StopBits),
        .DataOut(DataOut),
        .ErrorFlag(ErrorFlag),
        .ActiveFlag(ActiveFlag),
        .DoneFlag(DoneFlag)
    );

    typedef struct {
        logic [1:0] baud;
        logic [1:0] par;
        logic       len8;
        logic       stop2;
        logic [7:0] data;
        logic       flip;
        logic [1:0] stop_low;
        int         hold;
        logic [7:0] exp_data;
        logic [2:0] exp_err;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [10:0] obs[$];
    logic [10:0] exp_q[$];
    int          act_cnt = 0;
    int          last_active = 0;

    // Every DoneFlag pulse is recorded as {ErrorFlag, DataOut}; ActiveFlag width is measured per frame.
    always @(negedge clock) begin
        if (DoneFlag) begin
            obs.push_back({ErrorFlag, DataOut});
            last_active = act_cnt;
            act_cnt = 0;
        end else if (ActiveFlag) begin
            act_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int bit_clks(input logic [1:0] b);
        real hz;
        hz = 2400.0 * real'(32'd1 << b);
        return 16 * $rtoi(real'(CLK_FREQ) / (16.0 * hz) + 0.5);
    endfunction

    // Expected {ErrorFlag, DataOut} of a frame, straight from the framing rules.
    function automatic logic [10:0] model(input logic [1:0] p, input logic l8, input logic s2,
                                          input logic [7:0] d, input logic flip, input logic [1:0] sl);
        logic pe, se;
        pe = (p == 2'd1) || (p == 2'd2);
        se = sl[0] | (s2 & sl[1]);
        return {se, 1'b0, flip & pe, l8 ? d : {1'b0, d[6:0]}};
    endfunction

    // Transmitter: start, data LSB first, optional parity, stop bit(s); sl forces stop bits low.
    task automatic send_frame(input logic [1:0] b, input logic [1:0] p, input logic l8, input logic s2,
                              input logic [7:0] d, input logic flip, input logic [1:0] sl, input logic scramble);
        logic       bits[$];
        int         bc;
        logic [7:0] dm;
        bc = bit_clks(b);
        dm = l8 ? d : {1'b0, d[6:0]};
        BaudRate   = b;
        ParityType = p;
        DataLength = l8;
        StopBits   = s2;
        bits.push_back(1'b0);
        for (int i = 0; i < (l8 ? 8 : 7); i++) bits.push_back(d[i]);
        if (p == 2'd1) bits.push_back(~(^dm) ^ flip);
        else if (p == 2'd2) bits.push_back((^dm) ^ flip);
        bits.push_back(~sl[0]);
        if (s2) bits.push_back(~sl[1]);
        foreach (bits[k]) begin
            SerialIn = bits[k];
            for (int c = 0; c < bc; c++) begin
                @(negedge clock);
                if (scramble && k == 0 && c == 8) begin
                    BaudRate   = 2'($urandom);
                    ParityType = 2'($urandom);
                    DataLength = 1'($urandom);
                    StopBits   = 1'($urandom);
                end
            end
        end
    endtask

    vec_t        vecs[8];
    logic [10:0] r;
    logic [7:0]  last_data;

    initial begin
        vecs[0] = '{2'd2, 2'd0, 1'b1, 1'b0, 8'hA5, 1'b0, 2'b00, 0, 8'hA5, 3'b000};
        vecs[1] = '{2'd0, 2'd2, 1'b0, 1'b1, 8'h55, 1'b0, 2'b00, 0, 8'h55, 3'b000};
        vecs[2] = '{2'd3, 2'd1, 1'b1, 1'b0, 8'h3C, 1'b1, 2'b00, 0, 8'h3C, 3'b001};
        vecs[3] = '{2'd2, 2'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 2'b01, 3, 8'hFF, 3'b100};
        vecs[4] = '{2'd1, 2'd2, 1'b1, 1'b1, 8'h96, 1'b0, 2'b00, 0, 8'h96, 3'b000};
        vecs[5] = '{2'd3, 2'd3, 1'b0, 1'b0, 8'hC3, 1'b0, 2'b00, 0, 8'h43, 3'b000};
        vecs[6] = '{2'd1, 2'd1, 1'b0, 1'b1, 8'h00, 1'b1, 2'b00, 0, 8'h00, 3'b001};
        vecs[7] = '{2'd3, 2'd2, 1'b1, 1'b1, 8'h7E, 1'b0, 2'b11, 0, 8'h7E, 3'b100};

        ResetN = 1'b0;
        SerialIn = 1'b1;
        BaudRate = 2'd0;
        ParityType = 2'd0;
        DataLength = 1'b1;
        StopBits = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_data", 32'(DataOut), 32'h00);
        check("reset_err", 32'(ErrorFlag), 32'h0);
        check("reset_active", 32'(ActiveFlag), 32'h0);
        check("reset_done", 32'(DoneFlag), 32'h0);
        ResetN = 1'b1;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            int bc;
            bc = bit_clks(vecs[i].baud);
            send_frame(vecs[i].baud, vecs[i].par, vecs[i].len8, vecs[i].stop2, vecs[i].data,
                       vecs[i].flip, vecs[i].stop_low, 1'b0);
            if (vecs[i].hold > 0) begin
                SerialIn = 1'b0;
                repeat (vecs[i].hold * bc) @(negedge clock);
            end
            SerialIn = 1'b1;
            repeat (2 * bc) @(negedge clock);
            check($sformatf("vec%0d_done_count", i), 32'(obs.size()), 32'd1);
            if (obs.size() > 0) r = obs.pop_front();
            else r = 'x;
            obs.delete();
            check($sformatf("vec%0d_data", i), 32'(r[7:0]), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i), 32'(r[10:8]), 32'(vecs[i].exp_err));
            last_data = vecs[i].exp_data;
            if (i == 1) begin
                n_cmp++;
                if (last_active < 2672 || last_active > 2720) begin
                    n_fail++;
                    $display("FAIL active_width: got %0d cycles expected 2672..2720", last_active);
                end
            end
        end

        // Low pulse shorter than half a bit at 9600: false start, data held.
        BaudRate = 2'd2;
        SerialIn = 1'b0;
        repeat (24) @(negedge clock);
        SerialIn = 1'b1;
        repeat (3 * bit_clks(2'd2)) @(negedge clock);
        check("glitch_done_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) r = obs.pop_front();
        else r = 'x;
        obs.delete();
        check("glitch_data", 32'(r[7:0]), 32'(last_data));
        check("glitch_err", 32'(r[10:8]), 32'b010);

        // Random back-to-back frames with config inputs scrambled mid-frame.
        exp_q.delete();
        for (int n = 0; n < 20; n++) begin
            logic [1:0] b, p, sl;
            logic       l8, s2, flip;
            logic [7:0] d;
            b    = 2'($urandom_range(1, 3));
            p    = 2'($urandom_range(0, 3));
            l8   = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            flip = 1'($urandom_range(0, 1));
            sl   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (!s2) sl[1] = 1'b0;
            exp_q.push_back(model(p, l8, s2, d, flip, sl));
            send_frame(b, p, l8, s2, d, flip, sl, 1'b1);
            if (|sl) begin
                SerialIn = 1'b1;
                repeat (bit_clks(b)) @(negedge clock);
            end
        end
        SerialIn = 1'b1;
        repeat (3 * bit_clks(2'd1)) @(negedge clock);
        check("rand_count", 32'(obs.size()), 32'(exp_q.size()));
        for (int n = 0; n < exp_q.size() && n < obs.size(); n++)
            check($sformatf("rand%0d_frame", n), 32'(obs[n]), 32'(exp_q[n]));
        obs.delete();

        // Reset during bit 4 of 0x81 drops the frame; a resend is received cleanly.
        BaudRate = 2'd2;
        ParityType = 2'd0;
        DataLength = 1'b1;
        StopBits = 1'b0;
        SerialIn = 1'b0;
        repeat (64) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            SerialIn = (i == 0) ? 1'b1 : 1'b0;
            repeat (64) @(negedge clock);
        end
        SerialIn = 1'b0;
        repeat (32) @(negedge clock);
        check("midframe_active", 32'(ActiveFlag), 32'h1);
        ResetN = 1'b0;
        repeat (2) @(negedge clock);
        check("midreset_data", 32'(DataOut), 32'h00);
        check("midreset_err", 32'(ErrorFlag), 32'h0);
        check("midreset_active", 32'(ActiveFlag), 32'h0);
        SerialIn = 1'b1;
        ResetN = 1'b1;
        repeat (128) @(negedge clock);
        check("midreset_no_done", 32'(obs.size()), 32'd0);
        obs.delete();
        send_frame(2'd2, 2'd0, 1'b1, 1'b0, 8'h81, 1'b0, 2'b00, 1'b0);
        SerialIn = 1'b1;
        repeat (128) @(negedge clock);
        check("resend_done_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) r = obs.pop_front();
        else r = 'x;
        check("resend_data", 32'(r[7:0]), 32'h81);
        check("resend_err", 32'(r[10:8]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
